// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes shared with the ALU control decoder, plus the buffered-result entry layout.
package alu_pkg;
  localparam int ALUCTRL_W = 3;
  localparam logic [ALUCTRL_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALUCTRL_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALUCTRL_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALUCTRL_W-1:0] ALU_SUB = 3'b011;
  localparam logic [ALUCTRL_W-1:0] ALU_SLT = 3'b100;
  localparam int ALU_XLEN = 32;
  localparam int ALU_TAGW = 5;
  typedef struct packed {
    logic [ALU_XLEN-1:0] result;
    logic                zero;
    logic                illegal;
    logic [ALU_TAGW-1:0] tag;
  } alu_entry_t;
endpackage

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: circular result buffer with occupancy count, flush and async active-low reset.
module alu_result_fifo #(
  parameter int W = 39,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_data,
  output logic [W-1:0]  o_data,
  output logic [CW-1:0] o_count
);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [W-1:0]  r_last;
  logic [W-1:0]  w_head;
  assign w_head  = r_mem[r_rptr];
  // r_last keeps the most recent head so outputs hold steady while empty
  assign o_data  = (r_count != '0) ? w_head : r_last;
  assign o_count = r_count;
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_data;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_last  <= '0;
    end else begin
      if (r_count != '0) r_last <= w_head;
      if (i_flush) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (i_push) r_wptr <= r_wptr + 1'b1;
        if (i_pop) r_rptr <= r_rptr + 1'b1;
        r_count <= r_count + CW'(i_push) - CW'(i_pop);
      end
    end
  end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU whose results are buffered behind a valid/ready handshake
// so a downstream MEM/WB stall does not drop results.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN = ALU_XLEN,
  parameter int TAGW = ALU_TAGW,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ALUCTRL_W-1:0] aluctrl,
  input  logic [XLEN-1:0]      op_a,
  input  logic [XLEN-1:0]      op_b,
  input  logic [TAGW-1:0]      in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      result,
  output logic                 zero,
  output logic                 illegal,
  output logic [TAGW-1:0]      out_tag,
  output logic [CW-1:0]        count
);
  localparam int EW = XLEN + TAGW + 2;
  logic [XLEN-1:0] w_res;
  logic            w_illegal;
  logic            w_push;
  logic            w_pop;
  logic [EW-1:0]   w_entry;
  logic [EW-1:0]   w_head;
  assign w_illegal = aluctrl > ALU_SLT;
  always_comb begin
    w_res = (aluctrl == ALU_AND) ? op_a & op_b :
            (aluctrl == ALU_OR)  ? op_a | op_b :
            (aluctrl == ALU_ADD) ? op_a + op_b :
            (aluctrl == ALU_SUB) ? op_a - op_b :
            (aluctrl == ALU_SLT) ? XLEN'($signed(op_a) < $signed(op_b)) : '0;
  end
  // in_ready deliberately ignores out_ready to keep the upstream path short
  assign in_ready  = (count < CW'(DEPTH)) && !flush;
  assign out_valid = count != '0;
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign w_entry   = {w_res, w_res == '0, w_illegal, in_tag};
  assign {result, zero, illegal, out_tag} = w_head;
  alu_result_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (flush),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_entry),
    .o_data  (w_head),
    .o_count (count)
  );
  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    in_valid && !in_ready && !flush |=> $stable({aluctrl, op_a, op_b, in_tag}));
  a_count_max: assert property (@(posedge clk) disable iff (!rst_n) count <= CW'(DEPTH));
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed and randomized checks of alu_exec_unit against a queue-based reference model.
module tb_alu_exec_unit;
  import alu_pkg::*;
  localparam int XLEN = 32;
  localparam int TAGW = 5;
  localparam int DEPTH = 2;
  localparam int CW = $clog2(DEPTH) + 1;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, zero, illegal;
  logic [2:0] aluctrl = 0;
  logic [XLEN-1:0] op_a = 0, op_b = 0, result;
  logic [TAGW-1:0] in_tag = 0, out_tag;
  logic [CW-1:0] count;
  int n_checks = 0, n_fail = 0;
  typedef struct {
    logic [XLEN-1:0] res;
    logic            z;
    logic            ill;
    logic [TAGW-1:0] tag;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  alu_exec_unit #(.XLEN(XLEN), .TAGW(TAGW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .aluctrl(aluctrl), .op_a(op_a), .op_b(op_b), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .illegal(illegal),
    .out_tag(out_tag), .count(count)
  );

  function automatic exp_t model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                                 input logic [TAGW-1:0] t);
    exp_t e;
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.tag = t;
    e.ill = 0;
    case (c)
      3'd0: e.res = a & b;
      3'd1: e.res = a | b;
      3'd2: e.res = 32'((longint'(a) + longint'(b)) % 64'h1_0000_0000);
      3'd3: e.res = 32'((longint'(a) - longint'(b) + 64'h1_0000_0000) % 64'h1_0000_0000);
      3'd4: e.res = (sa < sb) ? 32'd1 : 32'd0;
      default: begin e.res = 0; e.ill = 1; end
    endcase
    e.z = (e.res == 0);
    return e;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    #12;
    n_checks++;
    if ({count, out_valid, result, zero, illegal, out_tag} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got cnt=%0d v=%b r=%h z=%b i=%b t=%0d required all zero",
               count, out_valid, result, zero, illegal, out_tag);
    end
    @(negedge clk);
    rst_n = 1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    tick();
  endtask

  task automatic test_directed();
    logic [2:0] c [6];
    logic [31:0] a [6];
    logic [31:0] b [6];
    logic [31:0] r [6];
    c = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLT};
    a = '{32'd5, 32'd9, 32'hF0F0, 32'h0F, 32'hFFFF_FFFF, 32'd1};
    b = '{32'd7, 32'd9, 32'hFF00, 32'hF0, 32'd1, 32'hFFFF_FFFF};
    r = '{32'd12, 32'd0, 32'hF000, 32'hFF, 32'd1, 32'd0};
    out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1; aluctrl = c[i]; op_a = a[i]; op_b = b[i]; in_tag = TAGW'(i + 1);
      tick();
      n_checks++;
      if ({out_valid, count, result, zero, illegal, out_tag} !== {1'b1, CW'(1), r[i], r[i] == 0, 1'b0, TAGW'(i + 1)}) begin
        n_fail++;
        $display("FAIL directed[%0d]: got v=%b cnt=%0d r=%h z=%b i=%b t=%0d required r=%h t=%0d",
                 i, out_valid, count, result, zero, illegal, out_tag, r[i], i + 1);
      end
    end
    in_valid = 0;
    tick();
    n_checks++;
    if ({out_valid, count, result} !== {1'b0, CW'(0), 32'd0} || out_tag !== TAGW'(6)) begin
      n_fail++;
      $display("FAIL directed_drain: got v=%b cnt=%0d r=%h t=%0d required empty holding r=0 t=6",
               out_valid, count, result, out_tag);
    end
  endtask

  task automatic test_wrap();
    logic [2:0] c [2];
    logic [31:0] a [2];
    logic [31:0] b [2];
    logic [31:0] r [2];
    c = '{ALU_ADD, ALU_SUB};
    a = '{32'hFFFF_FFFF, 32'd0};
    b = '{32'd1, 32'd1};
    r = '{32'd0, 32'hFFFF_FFFF};
    out_ready = 1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1; aluctrl = c[i]; op_a = a[i]; op_b = b[i]; in_tag = TAGW'(20 + i);
      tick();
      n_checks++;
      if ({out_valid, result, zero, illegal, out_tag} !== {1'b1, r[i], r[i] == 0, 1'b0, TAGW'(20 + i)}) begin
        n_fail++;
        $display("FAIL wrap[%0d]: got v=%b r=%h z=%b t=%0d required r=%h z=%b",
                 i, out_valid, result, zero, out_tag, r[i], r[i] == 0);
      end
    end
    in_valid = 0;
    tick();
  endtask

  task automatic test_backpressure();
    exp_t e [3];
    for (int i = 0; i < 3; i++) e[i] = model(ALU_ADD, 32'(100 * i), 32'd3, TAGW'(10 + i));
    out_ready = 0;
    in_valid = 1; aluctrl = ALU_ADD; op_a = 0; op_b = 3; in_tag = 10;
    tick();
    op_a = 100; in_tag = 11;
    tick();
    op_a = 200; in_tag = 12;
    #1;
    n_checks++;
    if ({count, in_ready} !== {CW'(2), 1'b0}) begin
      n_fail++;
      $display("FAIL bp_full: got cnt=%0d rdy=%b required cnt=2 rdy=0", count, in_ready);
    end
    tick();
    n_checks++;
    if ({count, in_ready, result, out_tag} !== {CW'(2), 1'b0, e[0].res, e[0].tag}) begin
      n_fail++;
      $display("FAIL bp_hold: got cnt=%0d rdy=%b r=%h t=%0d required cnt=2 rdy=0 r=%h t=%0d",
               count, in_ready, result, out_tag, e[0].res, e[0].tag);
    end
    out_ready = 1;
    for (int i = 1; i < 3; i++) begin
      tick();
      n_checks++;
      if ({out_valid, count, result, out_tag} !== {1'b1, CW'(1), e[i].res, e[i].tag}) begin
        n_fail++;
        $display("FAIL bp_drain[%0d]: got v=%b cnt=%0d r=%h t=%0d required cnt=1 r=%h t=%0d",
                 i, out_valid, count, result, out_tag, e[i].res, e[i].tag);
      end
    end
    in_valid = 0;
    tick();
    n_checks++;
    if ({out_valid, count} !== {1'b0, CW'(0)}) begin
      n_fail++;
      $display("FAIL bp_empty: got v=%b cnt=%0d required 0 0", out_valid, count);
    end
  endtask

  task automatic test_illegal();
    out_ready = 1;
    in_valid = 1; aluctrl = 3'b110; op_a = 3; op_b = 4; in_tag = 21;
    tick();
    in_valid = 0;
    n_checks++;
    if ({out_valid, result, zero, illegal, out_tag} !== {1'b1, 32'd0, 1'b1, 1'b1, TAGW'(21)}) begin
      n_fail++;
      $display("FAIL illegal: got v=%b r=%h z=%b i=%b t=%0d required v=1 r=0 z=1 i=1 t=21",
               out_valid, result, zero, illegal, out_tag);
    end
    tick();
  endtask

  task automatic test_flush();
    out_ready = 0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1; aluctrl = ALU_ADD; op_a = 32'(i); op_b = 100; in_tag = TAGW'(i);
      tick();
    end
    aluctrl = ALU_OR; op_a = 32'h55; op_b = 0; in_tag = 7; flush = 1;
    #1;
    n_checks++;
    if ({count, in_ready} !== {CW'(2), 1'b0}) begin
      n_fail++;
      $display("FAIL flush_cycle: got cnt=%0d rdy=%b required cnt=2 rdy=0", count, in_ready);
    end
    tick();
    flush = 0;
    in_tag = 9;
    #1;
    n_checks++;
    if ({count, out_valid, in_ready} !== {CW'(0), 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL flush_after: got cnt=%0d v=%b rdy=%b required 0 0 1", count, out_valid, in_ready);
    end
    out_ready = 1;
    tick();
    in_valid = 0;
    n_checks++;
    if ({out_valid, count, result, out_tag} !== {1'b1, CW'(1), 32'h55, TAGW'(9)}) begin
      n_fail++;
      $display("FAIL flush_next_op: got v=%b cnt=%0d r=%h t=%0d required v=1 cnt=1 r=55 t=9",
               out_valid, count, result, out_tag);
    end
    tick();
  endtask

  task automatic test_async_reset();
    out_ready = 0;
    in_valid = 1; aluctrl = ALU_ADD; op_a = 2; op_b = 3; in_tag = 4;
    tick();
    in_valid = 0;
    n_checks++;
    if ({out_valid, count} !== {1'b1, CW'(1)}) begin
      n_fail++;
      $display("FAIL arst_pre: got v=%b cnt=%0d required 1 1", out_valid, count);
    end
    #2;
    rst_n = 0;
    #1;
    n_checks++;
    if ({out_valid, count} !== {1'b0, CW'(0)}) begin
      n_fail++;
      $display("FAIL arst_immediate: got v=%b cnt=%0d required 0 0", out_valid, count);
    end
    @(negedge clk);
    rst_n = 1;
    out_ready = 1;
    tick();
    tick();
    n_checks++;
    if ({out_valid, count, in_ready} !== {1'b0, CW'(0), 1'b1}) begin
      n_fail++;
      $display("FAIL arst_no_stale: got v=%b cnt=%0d rdy=%b required 0 0 1", out_valid, count, in_ready);
    end
  endtask

  task automatic test_random();
    exp_t e;
    logic hold, acc, con;
    hold = 0;
    q.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!hold) begin
        in_valid = ($urandom_range(0, 3) != 0);
        aluctrl = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
        op_a = pick();
        op_b = pick();
        in_tag = TAGW'($urandom);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 24) == 0);
      #1;
      n_checks++;
      if ({count, in_ready, out_valid} !== {CW'(q.size()), (q.size() < DEPTH) && !flush, q.size() != 0}) begin
        n_fail++;
        $display("FAIL rand_ctrl[%0d]: got cnt=%0d rdy=%b v=%b required cnt=%0d", cyc, count, in_ready,
                 out_valid, q.size());
      end
      if (q.size() != 0) begin
        n_checks++;
        if ({result, zero, illegal, out_tag} !== {q[0].res, q[0].z, q[0].ill, q[0].tag}) begin
          n_fail++;
          $display("FAIL rand_head[%0d]: got r=%h z=%b i=%b t=%0d required r=%h z=%b i=%b t=%0d", cyc,
                   result, zero, illegal, out_tag, q[0].res, q[0].z, q[0].ill, q[0].tag);
        end
      end
      e = model(aluctrl, op_a, op_b, in_tag);
      acc = in_valid && (q.size() < DEPTH) && !flush;
      con = out_ready && (q.size() != 0) && !flush;
      hold = in_valid && !acc && !flush;
      tick();
      if (flush) q.delete();
      else begin
        if (con) void'(q.pop_front());
        if (acc) q.push_back(e);
      end
    end
    flush = 0;
    in_valid = 0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_wrap();
    test_backpressure();
    test_illegal();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
